// File: rtl/comparador_serial_izq_der.sv
// Bit-serial magnitude comparator that scans two N-bit operands from MSB to LSB,
// one bit per clock, stopping at the first differing bit. Start/done handshake.
module comparador_serial_izq_der #(
  parameter int N = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N-1:0]               A,
  input  logic [N-1:0]               B,
  output logic                       busy,
  output logic                       done,
  output logic                       a_gt_b,
  output logic                       a_lt_b,
  output logic                       a_eq_b,
  output logic [$clog2(N+1)-1:0]     bits_used
);

  localparam int CW = $clog2(N+1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is honoured only in IDLE, where A/B are captured on that
  // edge. busy is high for every COMPARE cycle; done is high for the single
  // DONE cycle and the result flags stay valid until the next accepted start.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    ra;
  logic [N-1:0]    rb;
  logic [IW-1:0]   idx;
  logic            bit_a;
  logic            bit_b;
  logic            last_bit;

  assign bit_a    = ra[idx];
  assign bit_b    = rb[idx];
  assign last_bit = (idx == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if ((bit_a != bit_b) || last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      COMPARE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, scan index, bit counter and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ra        <= '0;
      rb        <= '0;
      idx       <= '0;
      bits_used <= '0;
      a_gt_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra        <= A;
            rb        <= B;
            idx       <= IW'(N-1);
            bits_used <= '0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
          end
        end
        COMPARE: begin
          bits_used <= bits_used + CW'(1);
          if (bit_a && !bit_b) begin
            a_gt_b <= 1'b1;
          end else if (!bit_a && bit_b) begin
            a_lt_b <= 1'b1;
          end else if (last_bit) begin
            a_eq_b <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Directed bench for the N=3 left-to-right serial comparator: reset, handshake
// timing, flag hold, input isolation, mid-operation reset and an exhaustive sweep.
module tb_comparador_serial_izq_der;

  localparam int N  = 3;
  localparam int CW = $clog2(N+1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          busy;
  logic          done;
  logic          a_gt_b;
  logic          a_lt_b;
  logic          a_eq_b;
  logic [CW-1:0] bits_used;

  int n_assert = 0;
  int n_fail   = 0;

  comparador_serial_izq_der #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .bits_used (bits_used)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic gt, input logic lt, input logic eq);
    chk({tag, "_gt"}, 32'(a_gt_b), 32'(gt));
    chk({tag, "_lt"}, 32'(a_lt_b), 32'(lt));
    chk({tag, "_eq"}, 32'(a_eq_b), 32'(eq));
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic gt, input logic lt, input logic eq,
                     input int k, input string tag);
    int cnt;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    chk({tag, "_accept_clr"}, 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
    chk({tag, "_accept_bits"}, 32'(bits_used), 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2*N+4) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(k));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk_flags(tag, gt, lt, eq);
    chk({tag, "_bits"}, 32'(bits_used), 32'(k));
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    logic [N-1:0] x;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_bits", 32'(bits_used), 32'd0);

    // MSB differs: best case
    run(3'b101, 3'b011, 1'b1, 1'b0, 1'b0, 1, "msb_gt");

    // LSB differs, then flags hold while idle
    run(3'b010, 3'b011, 1'b0, 1'b1, 1'b0, 3, "lsb_lt");
    for (int i = 0; i < 5; i++) begin
      chk("hold_done", 32'(done), 32'd0);
      chk_flags("hold", 1'b0, 1'b1, 1'b0);
      chk("hold_bits", 32'(bits_used), 32'd3);
      @(negedge clk);
    end

    // Equal, then a_eq_b cleared on the next accept
    run(3'b110, 3'b110, 1'b0, 1'b0, 1'b1, 3, "equal");
    run(3'b110, 3'b100, 1'b1, 1'b0, 1'b0, 2, "mid_gt");

    // Start re-raised during busy with changed inputs
    A = 3'b100; B = 3'b000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("iso_busy", 32'(busy), 32'd1);
    A = 3'b000; B = 3'b111;
    @(negedge clk);
    chk("iso_done", 32'(done), 32'd1);
    chk_flags("iso_first", 1'b1, 1'b0, 1'b0);
    chk("iso_bits", 32'(bits_used), 32'd1);
    @(negedge clk);
    chk("iso_idle_busy", 32'(busy), 32'd0);
    chk("iso_idle_done", 32'(done), 32'd0);
    chk_flags("iso_idle", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("iso_second_busy", 32'(busy), 32'd1);
    chk_flags("iso_second_clr", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    A = 3'b111; B = 3'b000;
    @(negedge clk);
    chk("iso_second_done", 32'(done), 32'd1);
    chk_flags("iso_second", 1'b0, 1'b1, 1'b0);
    chk("iso_second_bits", 32'(bits_used), 32'd1);
    @(negedge clk);

    // Reset during the second busy cycle
    A = 3'b011; B = 3'b010; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_flags("abort", 1'b0, 1'b0, 1'b0);
    chk("abort_bits", 32'(bits_used), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run(3'b011, 3'b010, 1'b1, 1'b0, 1'b0, 3, "after_abort");

    // Exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        x = 3'(i ^ j);
        if (x[2])      k = 1;
        else if (x[1]) k = 2;
        else           k = 3;
        run(3'(i), 3'(j), i > j, i < j, i == j, k, "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/comparador_serial_izq_der.md
Name: comparador_serial_izq_der

Overview:
Sequential bit-serial magnitude comparator. It scans two N-bit operands from MSB to LSB (left to right), one bit per clock. It is the sequential, opposite-direction counterpart of the structural right-to-left comparator chain. Because the scan starts at the MSB, it stops at the first differing bit. It sits behind a start/done handshake so control logic can time comparisons and count cycles spent.

Parameters:
N, 3, operand width in bits (N >= 1)
CW, $clog2(N+1), width of the bit-count output (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request a comparison; honoured only in IDLE
A  input  N  operand A, sampled on the clock edge where start is accepted
B  input  N  operand B, sampled together with A
busy  output  1  high while the comparison is in progress (COMPARE state)
done  output  1  one-cycle pulse marking the results as newly valid
a_gt_b  output  1  result: A > B
a_lt_b  output  1  result: A < B
a_eq_b  output  1  result: A == B
bits_used  output  CW  number of bit positions examined to reach the decision (1..N)

Behaviour:
- One clock domain; all state changes on the rising edge of clk.
- rst is synchronous and active-high, and has priority over everything else, including mid-comparison.
- Reset values: state = IDLE; busy, done, a_gt_b, a_lt_b, a_eq_b = 0; bits_used = 0; internal operand registers and index = 0.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - busy = 0.
  - On an edge with start = 1: capture A into ra and B into rb; set idx = N-1 and bits_used = 0; clear all three result flags; go to COMPARE.
  - start = 0: stay in IDLE; the result outputs hold their last values.
- COMPARE (busy = 1), on each edge:
  - Increment bits_used.
  - If ra[idx] = 1 and rb[idx] = 0: set a_gt_b = 1; go to DONE.
  - If ra[idx] = 0 and rb[idx] = 1: set a_lt_b = 1; go to DONE.
  - Bits equal and idx = 0: set a_eq_b = 1; go to DONE.
  - Bits equal and idx > 0: decrement idx; stay in COMPARE.
- DONE (busy = 0, done = 1 for exactly this cycle): next edge goes to IDLE unconditionally. A start during DONE is ignored.
- Latency: start accepted at edge E0. If the first difference is at position N-k (k bits examined), then:
  - busy is high for k cycles;
  - done is high in cycle k+1 after E0;
  - bits_used = k.
  - Equal operands: k = N. Worst-case start-to-done is N+1 cycles; best case (MSB differs) is 2.
- Result flags are one-hot while done = 1 and stay stable through IDLE until the next accepted start clears them.
- A and B are not observed after capture; changing them during busy has no effect.
- start held high continuously: a new comparison is accepted every time the FSM reaches IDLE, i.e. one comparison per k+2 cycles.
- N = 1: a single COMPARE cycle; bits_used = 1 always.
- Reset asserted during COMPARE or DONE: next cycle is IDLE with all outputs at their reset values; no done pulse is produced for the aborted operation.

Test Plan:
- N=3, rst for 2 cycles, then start with A=101, B=011: busy high for 1 cycle; done in 2nd cycle after accept; a_gt_b=1, a_lt_b=0, a_eq_b=0, bits_used=1.
- A=010, B=011: busy for 3 cycles; done in 4th cycle; a_lt_b=1, bits_used=3. Flags hold through 5 idle cycles.
- A=110, B=110: a_eq_b=1, bits_used=3, done after 4 cycles. Then A=110, B=100: a_gt_b=1, bits_used=2. a_eq_b must be cleared on accept.
- Start A=100, B=000, then one cycle later raise start with A=000, B=111 and change inputs during busy: the first result is a_gt_b=1, bits_used=1. The second start is honoured only if still high in IDLE.
- Start A=011, B=010 (3-cycle case), assert rst in the 2nd busy cycle: next cycle busy=0, done never pulses, all flags 0 and bits_used=0. A fresh start then yields a_gt_b=1, bits_used=3.
- Exhaustive sweep over all i, j in 0..7 (including i==j), waiting for done each time: flags match i>j / i<j / i==j. bits_used = N minus the index of the highest differing bit, or N if equal. done is exactly one cycle wide every time.
